// File: rtl/block_check_arbiter.sv
// block_check_arbiter: two character-stream requesters share one begin/end checker, granted round-robin.
// Optional idle-stream abort (extra `timeout` port) is compiled in with `define BLOCK_ARB_TIMEOUT_EN.
module block_check_arbiter #(
    parameter int TO_W   = 8,
    parameter int TO_MAX = 200
) (
    input  logic        clk,
    input  logic        reset,
    input  logic [1:0]  req,
    input  logic [1:0]  valid,
    input  logic [1:0]  last,
    input  logic [7:0]  char0,
    input  logic [7:0]  char1,
    output logic [1:0]  ready,
    output logic [7:0]  chk_in,
    output logic        chk_ce,
    output logic        chk_rst,
    input  logic        chk_result,
    output logic        done,
    output logic        done_id,
    output logic        done_ok,
    output logic        busy,
    output logic [15:0] file_cnt
`ifdef BLOCK_ARB_TIMEOUT_EN
    ,
    output logic        timeout
`endif
);
    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_CLEAR  = 2'd1,
        ST_STREAM = 2'd2,
        ST_DONE   = 2'd3
    } state_t;

    state_t      state_r;
    logic        grant_r;
    logic        last_grant_r;
    logic [1:0]  ready_r;
    logic        done_r;
    logic        done_id_r;
    logic        busy_r;
    logic [15:0] file_cnt_r;

    logic        pick_s;
    logic        g_valid_s;
    logic        g_last_s;
    logic [7:0]  g_char_s;
    logic        xfer_s;

    // Round-robin choice: on a tie the requester that did not win last time is taken
    always_comb begin
        if (req == 2'b11) begin
            pick_s = ~last_grant_r;
        end else if (req[1]) begin
            pick_s = 1'b1;
        end else begin
            pick_s = 1'b0;
        end
    end

    // Handshake view of the granted requester only; the other side is ignored
    always_comb begin
        if (grant_r) begin
            g_valid_s = valid[1];
            g_last_s  = last[1];
            g_char_s  = char1;
        end else begin
            g_valid_s = valid[0];
            g_last_s  = last[0];
            g_char_s  = char0;
        end
    end

    assign xfer_s = (state_r == ST_STREAM) & g_valid_s;

`ifdef BLOCK_ARB_TIMEOUT_EN
    localparam logic [TO_W-1:0] TO_LIM = TO_W'(TO_MAX - 1);

    logic [TO_W-1:0] to_cnt_r;
    logic            timeout_r;
    logic            to_hit_s;

    assign to_hit_s = (state_r == ST_STREAM) & ~g_valid_s & (to_cnt_r == TO_LIM);

    // Idle counter: zero outside STREAM and on every transfer, counts stalled STREAM cycles
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            to_cnt_r <= {TO_W{1'b0}};
        end else if ((state_r != ST_STREAM) || g_valid_s) begin
            to_cnt_r <= {TO_W{1'b0}};
        end else begin
            to_cnt_r <= to_cnt_r + {{(TO_W-1){1'b0}}, 1'b1};
        end
    end

    assign timeout = timeout_r;
    assign done_ok = done_r & chk_result & ~timeout_r;
`else
    logic unused_cfg_s;
    assign unused_cfg_s = (TO_W > 0) ^ (TO_MAX > 0);
    assign done_ok      = done_r & chk_result;
`endif

    // Controller FSM with registered grant, ready, done and bookkeeping outputs
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_r      <= ST_IDLE;
            grant_r      <= 1'b0;
            last_grant_r <= 1'b1;
            ready_r      <= 2'b00;
            done_r       <= 1'b0;
            done_id_r    <= 1'b0;
            busy_r       <= 1'b0;
            file_cnt_r   <= 16'd0;
`ifdef BLOCK_ARB_TIMEOUT_EN
            timeout_r    <= 1'b0;
`endif
        end else begin
            case (state_r)
                ST_IDLE: begin
                    done_r <= 1'b0;
                    if (|req) begin
                        grant_r      <= pick_s;
                        last_grant_r <= pick_s;
                        busy_r       <= 1'b1;
                        state_r      <= ST_CLEAR;
                    end else begin
                        state_r <= ST_IDLE;
                    end
                end
                ST_CLEAR: begin
                    ready_r <= grant_r ? 2'b10 : 2'b01;
                    state_r <= ST_STREAM;
                end
                ST_STREAM: begin
                    if (xfer_s && g_last_s) begin
                        ready_r    <= 2'b00;
                        done_r     <= 1'b1;
                        done_id_r  <= grant_r;
                        file_cnt_r <= file_cnt_r + 16'd1;
                        state_r    <= ST_DONE;
                    end
`ifdef BLOCK_ARB_TIMEOUT_EN
                    else if (to_hit_s) begin
                        ready_r    <= 2'b00;
                        done_r     <= 1'b1;
                        done_id_r  <= grant_r;
                        timeout_r  <= 1'b1;
                        file_cnt_r <= file_cnt_r + 16'd1;
                        state_r    <= ST_DONE;
                    end
`endif
                    else begin
                        state_r <= ST_STREAM;
                    end
                end
                ST_DONE: begin
                    done_r  <= 1'b0;
                    busy_r  <= 1'b0;
`ifdef BLOCK_ARB_TIMEOUT_EN
                    timeout_r <= 1'b0;
`endif
                    state_r <= ST_IDLE;
                end
                default: begin
                    ready_r <= 2'b00;
                    done_r  <= 1'b0;
                    busy_r  <= 1'b0;
                    state_r <= ST_IDLE;
                end
            endcase
        end
    end

    assign ready    = ready_r;
    assign done     = done_r;
    assign done_id  = done_id_r;
    assign busy     = busy_r;
    assign file_cnt = file_cnt_r;
    assign chk_ce   = xfer_s;
    assign chk_in   = (state_r == ST_STREAM) ? g_char_s : 8'd32;
    // Checker is also held clear for as long as reset is asserted
    assign chk_rst  = (state_r == ST_CLEAR) | ~reset;

endmodule
